ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs) to the keyboard

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_host_tx_if.sv | 27 ++
 rtl/ps2_line_sync.sv | 27 ++
 rtl/ps2_host_tx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame geometry and parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SHIFT,
        WAIT_ACK,
        RECOVER,
        ERR
    } ps2_state_t;

    // Data bits + parity + stop shifted out after the start bit.
    localparam int FRAME_BITS = 10;
    // Device clock fall on which the ACK bit is sampled.
    localparam int ACK_FALL   = 11;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte handshake plus open-drain pad signals of the PS/2 host transmitter.
interface ps2_host_tx_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;

    // Client and pad side: issues bytes and supplies the raw pad levels.
    modport master (
        output tx_valid, tx_data, ps2_clk_in, ps2_data_in,
        input  tx_ready, tx_done, tx_error, busy, ps2_clk_drive_low, ps2_data_drive_low
    );

    // Transmitter side.
    modport slave (
        input  tx_valid, tx_data, ps2_clk_in, ps2_data_in,
        output tx_ready, tx_done, tx_error, busy, ps2_clk_drive_low, ps2_data_drive_low
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one asynchronous PS/2 line plus falling-edge detect.
module ps2_line_sync (
    input  logic clk,
    input  logic srst,
    input  logic line_in,
    output logic line_sync,
    output logic line_fall
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    // Reset to the idle (pulled-up) level so leaving reset never fakes a fall.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= 2'b11;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], line_in};
            prev_reg <= sync_reg[1];
        end
    end

    assign line_sync = sync_reg[1];
    assign line_fall = prev_reg & ~sync_reg[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one byte on device
// clock falls, then check the device ACK and wait for the bus to go idle.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int REQUEST_CYCLES = 25,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic         CLK_25MHZ,
    input  logic         RESET,
    ps2_host_tx_if.slave bus
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQUEST_LAST = CNT_W'(REQUEST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [3:0]            bit_idx_reg, bit_idx_next;
    logic [FRAME_BITS-1:0] frame_reg, frame_next;
    logic                  data_low_reg, data_low_next;

    logic clk_sync, clk_fall, data_sync, data_fall_unused;
    logic timeout_hit;
    logic tx_ready, tx_done, tx_error;

    ps2_line_sync u_clk_sync (
        .clk       (CLK_25MHZ),
        .srst      (RESET),
        .line_in   (bus.ps2_clk_in),
        .line_sync (clk_sync),
        .line_fall (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk       (CLK_25MHZ),
        .srst      (RESET),
        .line_in   (bus.ps2_data_in),
        .line_sync (data_sync),
        .line_fall (data_fall_unused)
    );

    assign timeout_hit = (cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            frame_reg    <= '0;
            data_low_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            frame_reg    <= frame_next;
            data_low_reg <= data_low_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        frame_next    = frame_reg;
        data_low_next = data_low_reg;
        tx_ready      = 1'b0;
        tx_done       = 1'b0;
        tx_error      = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_ready      = 1'b1;
                data_low_next = 1'b0;
                if (bus.tx_valid) begin
                    state_next   = INHIBIT;
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    frame_next   = {1'b1, odd_parity(bus.tx_data), bus.tx_data};
                end
            end
            INHIBIT: begin
                if (cnt_reg == INHIBIT_LAST) begin
                    state_next    = REQUEST;
                    cnt_next      = '0;
                    data_low_next = 1'b1;   // start bit goes low while the clock is still held
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            REQUEST: begin
                if (cnt_reg == REQUEST_LAST) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SHIFT: begin
                if (clk_fall) begin
                    cnt_next      = '0;
                    data_low_next = ~frame_reg[bit_idx_reg];
                    bit_idx_next  = bit_idx_reg + 4'd1;
                    if (bit_idx_reg == 4'(FRAME_BITS - 1))
                        state_next = WAIT_ACK;
                end else if (timeout_hit) begin
                    state_next    = ERR;
                    data_low_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (clk_fall) begin
                    cnt_next     = '0;
                    bit_idx_next = 4'(ACK_FALL);
                    state_next   = data_sync ? ERR : RECOVER;
                end else if (timeout_hit) begin
                    state_next = ERR;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RECOVER: begin
                // The byte only counts as delivered once the device has let go of both lines.
                if (clk_sync && data_sync) begin
                    state_next = IDLE;
                    tx_done    = 1'b1;
                end else if (clk_fall) begin
                    cnt_next = '0;
                end else if (timeout_hit) begin
                    state_next = ERR;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ERR: begin
                tx_error      = 1'b1;
                data_low_next = 1'b0;
                state_next    = IDLE;
            end
            default: begin
                state_next    = IDLE;
                data_low_next = 1'b0;
            end
        endcase
    end

    assign bus.tx_ready           = tx_ready;
    assign bus.tx_done            = tx_done;
    assign bus.tx_error           = tx_error;
    assign bus.busy               = (state_reg != IDLE);
    assign bus.ps2_clk_drive_low  = (state_reg == INHIBIT) || (state_reg == REQUEST);
    assign bus.ps2_data_drive_low = data_low_reg;

endmodule
